// File: rtl/bnn_control_if.sv
// Host and datapath signals of the BNN sequencer.
// master: the sequencer; slave: host plus PE array and memories.
interface bnn_control_if;
  logic        start;
  logic        idle;
  logic [15:0] load;
  logic [3:0]  sum_shift;
  logic        sum_enb;
  logic        beta_enb;
  logic [8:0]  weight_addr_rd;
  logic [6:0]  activation_addr_rd;
  logic [6:0]  activation_addr_wr;
  logic [15:0] activation_enb_wr;
  logic [7:0]  alpha_addr_rd;

  modport master (
    input  start,
    output idle, load, sum_shift, sum_enb, beta_enb,
    output weight_addr_rd, activation_addr_rd,
    output activation_addr_wr, activation_enb_wr,
    output alpha_addr_rd
  );

  modport slave (
    output start,
    input  idle, load, sum_shift, sum_enb, beta_enb,
    input  weight_addr_rd, activation_addr_rd,
    input  activation_addr_wr, activation_enb_wr,
    input  alpha_addr_rd
  );
endinterface

// File: rtl/bnn_control.sv
// BNN accelerator sequencer: layer/group/word/PE walk, registered outputs.
// BNN_CTRL_ASSERT_EN compiles in simulation assertions.
module bnn_control #(
  parameter int NUM_LAYERS = 2,
  parameter int NUM_WORDS  = 4
) (
  input  logic          clk,
  input  logic          rst,
  bnn_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_BETA, S_LOAD, S_ACC, S_THRESH
  } state_t;

  localparam logic [5:0]  W_LAST = 6'(NUM_WORDS - 1);
  localparam logic [5:0]  L_LAST = 6'(NUM_LAYERS - 1);
  localparam logic [31:0] NW     = 32'(NUM_WORDS);

  state_t      state_q, state_d;
  logic [5:0]  l_q, l_d, g_q, g_d, w_q, w_d;
  logic [3:0]  p_q, p_d;
  logic [31:0] lg;

  logic        idle_q, idle_d;
  logic [15:0] load_q, load_d;
  logic [3:0]  shift_q, shift_d;
  logic        sum_q, sum_d;
  logic        beta_q, beta_d;
  logic [8:0]  wa_q, wa_d;
  logic [6:0]  ard_q, ard_d;
  logic [6:0]  awr_q, awr_d;
  logic [15:0] ewr_q, ewr_d;
  logic [7:0]  al_q, al_d;

  always_comb begin
    state_d = state_q;
    l_d = l_q;
    g_d = g_q;
    w_d = w_q;
    p_d = p_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_BETA;
        l_d = '0;
        g_d = '0;
        w_d = '0;
        p_d = '0;
      end
      S_BETA: state_d = S_LOAD;
      S_LOAD: begin
        p_d = p_q + 4'd1;
        if (p_q == 4'd15) state_d = S_ACC;
      end
      S_ACC: begin
        if (w_q < W_LAST) begin
          w_d = w_q + 6'd1;
          state_d = S_LOAD;
        end else begin
          state_d = S_THRESH;
        end
      end
      S_THRESH: begin
        p_d = p_q + 4'd1;
        if (p_q == 4'd15) begin
          w_d = '0;
          state_d = S_BETA;
          if (g_q < W_LAST) begin
            g_d = g_q + 6'd1;
          end else if (l_q < L_LAST) begin
            g_d = '0;
            l_d = l_q + 6'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs follow the next state so they register alongside it
    lg = 32'(l_d) * NW + 32'(g_d);
    idle_d  = (state_d == S_IDLE);
    beta_d  = (state_d == S_BETA);
    sum_d   = (state_d == S_ACC);
    load_d  = '0;
    ewr_d   = '0;
    shift_d = '0;
    wa_d    = wa_q;
    ard_d   = ard_q;
    awr_d   = awr_q;
    al_d    = al_q;
    unique case (state_d)
      S_BETA: al_d = 8'(lg << 4);
      S_LOAD: begin
        load_d = 16'd1 << p_d;
        wa_d   = 9'((((lg << 4) + 32'(p_d)) * NW) + 32'(w_d));
        ard_d  = {l_d[0], w_d};
      end
      S_ACC: ard_d = {l_d[0], w_d};
      S_THRESH: begin
        shift_d = p_d;
        ewr_d   = 16'd1 << p_d;
        al_d    = 8'((lg << 4) + 32'(p_d));
        awr_d   = {~l_d[0], g_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      g_q     <= '0;
      w_q     <= '0;
      p_q     <= '0;
      idle_q  <= 1'b1;
      load_q  <= '0;
      shift_q <= '0;
      sum_q   <= 1'b0;
      beta_q  <= 1'b0;
      wa_q    <= '0;
      ard_q   <= '0;
      awr_q   <= '0;
      ewr_q   <= '0;
      al_q    <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      g_q     <= g_d;
      w_q     <= w_d;
      p_q     <= p_d;
      idle_q  <= idle_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      beta_q  <= beta_d;
      wa_q    <= wa_d;
      ard_q   <= ard_d;
      awr_q   <= awr_d;
      ewr_q   <= ewr_d;
      al_q    <= al_d;
    end
  end

  assign bus.idle               = idle_q;
  assign bus.load               = load_q;
  assign bus.sum_shift          = shift_q;
  assign bus.sum_enb            = sum_q;
  assign bus.beta_enb           = beta_q;
  assign bus.weight_addr_rd     = wa_q;
  assign bus.activation_addr_rd = ard_q;
  assign bus.activation_addr_wr = awr_q;
  assign bus.activation_enb_wr  = ewr_q;
  assign bus.alpha_addr_rd      = al_q;

`ifdef BNN_CTRL_ASSERT_EN
  logic [31:0] lg_chk, wa_full, al_full;

  always_comb begin
    lg_chk  = 32'(l_q) * NW + 32'(g_q);
    wa_full = (((lg_chk << 4) + 32'(p_q)) * NW) + 32'(w_q);
    al_full = (lg_chk << 4) + 32'(p_q);
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(load_q)) else $error("load not one-hot");
      assert ($onehot0(ewr_q)) else $error("enb_wr not one-hot");
      assert ($onehot0({|load_q, sum_q, beta_q, |ewr_q}))
        else $error("strobes overlap");
      assert (wa_full < 32'd512) else $error("weight addr range");
      assert (al_full < 32'd256) else $error("alpha addr range");
      assert (w_q < 6'(NUM_WORDS)) else $error("word range");
      assert (idle_q == (state_q == S_IDLE)) else $error("idle mismatch");
    end
  end
`endif

endmodule

// File: tb/tb_bnn_control.sv
// Directed bench for bnn_control at default parameters.
module tb_bnn_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bnn_control_if bus ();

  bnn_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idle, load, se, be, sh, ew;
    int wa, ard, awr, al;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int cyc, int idle, int load, int se,
                              int be, int sh, int ew, int wa,
                              int ard, int awr, int al);
    vec_t v;
    v.cyc = cyc; v.idle = idle; v.load = load; v.se = se;
    v.be = be; v.sh = sh; v.ew = ew; v.wa = wa;
    v.ard = ard; v.awr = awr; v.al = al;
    return v;
  endfunction

  function automatic void chk(string nm, int c, int act, int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, act, exp);
      end
    end
  endfunction

  function automatic void chk_rst(string nm);
    logic [69:0] got;
    logic [69:0] want;
    got = {bus.idle, bus.load, bus.sum_shift, bus.sum_enb,
           bus.beta_enb, bus.weight_addr_rd, bus.activation_addr_rd,
           bus.activation_addr_wr, bus.activation_enb_wr,
           bus.alpha_addr_rd};
    want = {1'b1, 69'd0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_len(input int mid, output int len);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    len = 0;
    while (!bus.idle && len < 2000) begin
      len++;
      bus.start = (len == mid);
      step();
    end
    bus.start = 1'b0;
  endtask

  int len;
  int guard;

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(2 + i, 0, 1 << i, 0, 0, -1, 0, 4 * i, 0, 0, 0));
      vecs.push_back(mk(19 + i, 0, 1 << i, 0, 0, -1, 0, 4 * i + 1, 1, 0, 0));
      vecs.push_back(mk(70 + i, 0, 0, 0, 0, i, 1 << i, 63, 3, 64, i));
    end
    vecs.push_back(mk(1, 0, 0, 0, 1, -1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(18, 0, 0, 1, 0, -1, 0, 60, 0, 0, 0));
    vecs.push_back(mk(86, 0, 0, 0, 1, -1, 0, 63, 3, 64, 16));
    vecs.push_back(mk(341, 0, 0, 0, 1, -1, 0, 255, 3, 67, 64));
    vecs.push_back(mk(342, 0, 1, 0, 0, -1, 0, 256, 64, 67, 64));
    vecs.push_back(mk(597, 0, 1, 0, 0, -1, 0, 448, 64, 2, 112));
    vecs.push_back(mk(614, 0, 1, 0, 0, -1, 0, 449, 65, 2, 112));
    vecs.push_back(mk(631, 0, 1, 0, 0, -1, 0, 450, 66, 2, 112));
    vecs.push_back(mk(648, 0, 1, 0, 0, -1, 0, 451, 67, 2, 112));
    vecs.push_back(mk(663, 0, 32768, 0, 0, -1, 0, 511, 67, 2, 112));
    vecs.push_back(mk(664, 0, 0, 1, 0, -1, 0, 511, 67, 2, 112));
    vecs.push_back(mk(680, 0, 0, 0, 0, 15, 32768, 511, 67, 3, 127));
    vecs.push_back(mk(681, 1, 0, 0, 0, -1, 0, 511, 67, 3, 127));

    // reset and quiet idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_rst("reset");
    for (int i = 0; i < 20; i++) begin
      step();
      chk_rst("idle_quiet");
    end

    // full default run against the vector table
    bus.start = 1'b1;
    for (int c = 1; c <= 681; c++) begin
      step();
      bus.start = 1'b0;
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) begin
          chk("idle", c, int'(bus.idle), vecs[i].idle);
          chk("load", c, int'(bus.load), vecs[i].load);
          chk("sum_enb", c, int'(bus.sum_enb), vecs[i].se);
          chk("beta_enb", c, int'(bus.beta_enb), vecs[i].be);
          chk("sum_shift", c, int'(bus.sum_shift), vecs[i].sh);
          chk("enb_wr", c, int'(bus.activation_enb_wr), vecs[i].ew);
          chk("weight_addr", c, int'(bus.weight_addr_rd), vecs[i].wa);
          chk("act_rd", c, int'(bus.activation_addr_rd), vecs[i].ard);
          chk("act_wr", c, int'(bus.activation_addr_wr), vecs[i].awr);
          chk("alpha", c, int'(bus.alpha_addr_rd), vecs[i].al);
        end
      end
    end

    // plain run length, then run with a stray start mid-run
    step();
    run_len(0, len);
    chk("run_len", 0, len, 680);
    step();
    run_len(100, len);
    chk("run_len_midstart", 0, len, 680);

    // start held high: one idle cycle then a new BETA
    step();
    bus.start = 1'b1;
    step();
    chk("held_beta0", 1, int'(bus.beta_enb), 1);
    guard = 0;
    while (!bus.idle && guard < 2000) begin
      guard++;
      step();
    end
    chk("held_len", 0, guard, 680);
    chk("held_idle", 681, int'(bus.idle), 1);
    step();
    chk("held_beta1", 682, int'(bus.beta_enb), 1);
    chk("held_busy", 682, int'(bus.idle), 0);
    bus.start = 1'b0;

    // reset at cycle 300 of this run
    for (int c = 2; c < 300; c++) step();
    chk("pre_rst_busy", 299, int'(bus.idle), 0);
    rst = 1'b1;
    step();
    chk_rst("rst_midrun");
    rst = 1'b0;
    step();
    chk_rst("after_rst");
    run_len(0, len);
    chk("run_after_rst", 0, len, 680);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
